// File: rtl/commfifo_h2d_arb.sv
`default_nettype none
// ============================================================================
//  Module   : commfifo_h2d_arb
//  Purpose  : Round-robin arbiter that shares the single h2d comm FIFO write
//             port between NCH host-side byte streams. Each grant emits one
//             header byte {4'hA, channel} and then forwards up to MAXBURST
//             data bytes from the granted channel before rotating.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_clk            clock, all logic on the rising edge
//    i_reset          synchronous active-high reset
//    i_req_valid[NCH] per-channel byte available
//    i_req_data       per-channel byte, channel k at [8k+7:8k]
//    i_req_last[NCH]  per-channel end-of-packet marker (qualified by valid)
//    o_req_ready[NCH] per-channel byte accepted when valid & ready
//    o_fifo_wr        write strobe to the h2d FIFO
//    o_fifo_data      byte to the h2d FIFO
//    i_fifo_not_full  h2d FIFO has room
//    o_grant          currently granted channel
//    o_busy           high while sending a header or data
//  Build option
//    COMMFIFO_ARB_PRIO_EN : when defined, channel 0 has strict priority and
//                           the remaining channels rotate among themselves.
// ============================================================================
module commfifo_h2d_arb #(
    parameter int NCH      = 4,
    parameter int CHW      = 2,
    parameter int MAXBURST = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [NCH-1:0]   i_req_valid,
    input  logic [NCH*8-1:0] i_req_data,
    input  logic [NCH-1:0]   i_req_last,
    output logic [NCH-1:0]   o_req_ready,
    output logic             o_fifo_wr,
    output logic [7:0]       o_fifo_data,
    input  logic             i_fifo_not_full,
    output logic [CHW-1:0]   o_grant,
    output logic             o_busy
);

    localparam int CNTW = $clog2(MAXBURST + 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_HDR  = 2'd1;
    localparam logic [1:0] c_ST_DATA = 2'd2;

`ifdef COMMFIFO_ARB_PRIO_EN
    localparam bit c_PRIO_EN = 1'b1;
`else
    localparam bit c_PRIO_EN = 1'b0;
`endif

    logic [1:0]      state_q,  state_d;
    logic [CHW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CHW-1:0]  grant_q,  grant_d;
    logic [CNTW-1:0] cnt_q,    cnt_d;

    logic            w_sel_found;
    logic [CHW-1:0]  w_sel;
    logic            w_cur_valid;
    logic            w_cur_last;
    logic [7:0]      w_cur_data;
    logic            w_xfer;
    logic [CNTW-1:0] w_cnt_inc;

    // Next-channel search starting one past the last served channel. In
    // priority mode channel 0 pre-empts the search and is excluded from it.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel       = '0;
        if (c_PRIO_EN && i_req_valid[0]) begin
            w_sel_found = 1'b1;
        end else begin
            for (int i = 1; i <= NCH; i++) begin
                logic [CHW-1:0] w_idx;
                w_idx = CHW'((int'(rr_ptr_q) + i) % NCH);
                if (!w_sel_found && i_req_valid[w_idx] &&
                    !(c_PRIO_EN && (w_idx == '0))) begin
                    w_sel_found = 1'b1;
                    w_sel       = w_idx;
                end
            end
        end
    end

    assign w_cur_valid = i_req_valid[grant_q];
    assign w_cur_last  = i_req_last[grant_q];
    assign w_cur_data  = i_req_data[8*grant_q +: 8];
    assign w_cnt_inc   = cnt_q + CNTW'(1);

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        o_fifo_wr   = 1'b0;
        o_fifo_data = 8'h00;
        o_req_ready = '0;
        w_xfer      = 1'b0;

        case (state_q)
            c_ST_IDLE: begin
                if (w_sel_found) begin
                    grant_d = w_sel;
                    state_d = c_ST_HDR;
                end
            end

            c_ST_HDR: begin
                o_fifo_wr   = i_fifo_not_full;
                o_fifo_data = {4'hA, 4'(grant_q)};
                if (i_fifo_not_full) begin
                    cnt_d   = '0;
                    state_d = c_ST_DATA;
                end
            end

            c_ST_DATA: begin
                o_req_ready[grant_q] = i_fifo_not_full;
                w_xfer               = w_cur_valid & i_fifo_not_full;
                o_fifo_wr            = w_xfer;
                o_fifo_data          = w_cur_data;
                if (w_xfer) begin
                    cnt_d = w_cnt_inc;
                end
                // A burst ends on last, on reaching MAXBURST, or on a bubble
                // from the requester while the FIFO could have accepted.
                if ((w_xfer && (w_cur_last || (w_cnt_inc == CNTW'(MAXBURST)))) ||
                    (i_fifo_not_full && !w_cur_valid)) begin
                    state_d = c_ST_IDLE;
                    if (!c_PRIO_EN || (grant_q != '0)) begin
                        rr_ptr_d = grant_q;
                    end
                end
            end

            default: state_d = c_ST_IDLE;
        endcase

        // A burst cut by reset must not leak another byte on the reset edge.
        if (i_reset) begin
            o_fifo_wr   = 1'b0;
            o_req_ready = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= c_ST_IDLE;
            rr_ptr_q <= CHW'(NCH - 1);
            grant_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_grant = grant_q;
    assign o_busy  = (state_q != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_commfifo_h2d_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_commfifo_h2d_arb
//  Purpose  : Directed self-checking bench for commfifo_h2d_arb (NCH=4,
//             MAXBURST=8). Per-channel byte queues act as requesters and a
//             sink queue captures every byte written into the h2d FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_commfifo_h2d_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data  = '0;
    logic [3:0]  req_last  = '0;
    logic [3:0]  req_ready;
    logic        fifo_wr;
    logic [7:0]  fifo_data;
    logic        fifo_not_full = 1'b1;
    logic [1:0]  grant;
    logic        busy;

    commfifo_h2d_arb #(.NCH(4), .CHW(2), .MAXBURST(8)) dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_req_valid     (req_valid),
        .i_req_data      (req_data),
        .i_req_last      (req_last),
        .o_req_ready     (req_ready),
        .o_fifo_wr       (fifo_wr),
        .o_fifo_data     (fifo_data),
        .i_fifo_not_full (fifo_not_full),
        .o_grant         (grant),
        .o_busy          (busy)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    int         t0;
    logic [7:0] q_data [4][$];
    bit         q_last [4][$];
    bit [3:0]   pend_pop  = '0;
    bit         bubble_en = 1'b0;
    logic [7:0] wq[$];
    int         wcyc[$];
    logic [7:0] exp_q[$];
    logic [7:0] hq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: retire last cycle's handshakes, present queue heads,
    // then capture this cycle's handshakes and FIFO write.
    task automatic cycle_start(input bit nf, input bit r);
        logic [3:0]  v, l;
        logic [31:0] d;
        @(negedge clk);
        cyc++;
        fifo_not_full = nf;
        rst           = r;
        v = '0; l = '0; d = '0;
        for (int c = 0; c < 4; c++) begin
            bit bub;
            bub = 1'b0;
            if (pend_pop[c]) begin
                void'(q_data[c].pop_front());
                void'(q_last[c].pop_front());
                bub = bubble_en;
            end
            if (q_data[c].size() > 0 && !bub) begin
                v[c]         = 1'b1;
                d[c*8 +: 8]  = q_data[c][0];
                l[c]         = q_last[c][0];
            end
        end
        req_valid = v;
        req_data  = d;
        req_last  = l;
        #1;
        pend_pop = req_valid & req_ready;
        if (fifo_wr && !rst) begin
            wq.push_back(fifo_data);
            wcyc.push_back(cyc);
        end
    endtask

    task automatic push(input int c, input logic [7:0] b, input bit last);
        q_data[c].push_back(b);
        q_last[c].push_back(last);
    endtask

    task automatic do_reset();
        for (int c = 0; c < 4; c++) begin
            q_data[c].delete();
            q_last[c].delete();
        end
        pend_pop = '0;
        cycle_start(1'b1, 1'b1);
        cycle_start(1'b1, 1'b1);
        chk("rst fifo_wr",   fifo_wr,   0);
        chk("rst fifo_data", fifo_data, 0);
        chk("rst ready",     req_ready, 0);
        chk("rst grant",     grant,     0);
        chk("rst busy",      busy,      0);
        rst = 1'b0;
        wq.delete();
        wcyc.delete();
    endtask

    task automatic check_sink(input string tag);
        chk($sformatf("%s count", tag), wq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < wq.size())
                chk($sformatf("%s byte%0d", tag, i), wq[i], exp_q[i]);
    endtask

    initial begin
        // ---------------- single packet on channel 2 ----------------
        do_reset();
        push(2, 8'h11, 0); push(2, 8'h22, 0); push(2, 8'h33, 1);
        t0 = cyc + 1;
        for (int k = 0; k <= 5; k++) begin
            cycle_start(1'b1, 1'b0);
            if (k == 2) chk("single grant", grant, 2);
            if (k == 4) chk("single busy c4", busy, 1);
            if (k == 5) chk("single busy c5", busy, 0);
        end
        exp_q = '{8'hA2, 8'h11, 8'h22, 8'h33};
        check_sink("single");
        if (wcyc.size() == 4) begin
            chk("single hdr cycle",   wcyc[0] - t0, 1);
            chk("single last cycle",  wcyc[3] - t0, 4);
        end

        // ---------------- burst limit: 12 bytes on channel 1 ----------------
        do_reset();
        for (int i = 0; i < 12; i++) push(1, 8'h40 + 8'(i), 0);
        for (int k = 0; k < 20; k++) cycle_start(1'b1, 1'b0);
        exp_q = '{8'hA1, 8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47,
                  8'hA1, 8'h48, 8'h49, 8'h4A, 8'h4B};
        check_sink("burst");
        if (wcyc.size() >= 10) chk("burst hdr2 gap", wcyc[9] - wcyc[8], 2);

        // ---------------- round-robin fairness, 1-byte packets ----------------
        do_reset();
        bubble_en = 1'b1;
        for (int j = 0; j < 4; j++)
            for (int c = 0; c < 4; c++) push(c, 8'(c*16 + j), 1);
        for (int k = 0; k < 20; k++) cycle_start(1'b1, 1'b0);
        bubble_en = 1'b0;
        hq.delete();
        foreach (wq[i]) if (wq[i][7:4] == 4'hA) hq.push_back(wq[i]);
`ifdef COMMFIFO_ARB_PRIO_EN
        exp_q = '{8'hA0, 8'hA1, 8'hA0, 8'hA2, 8'hA0, 8'hA3};
`else
        exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
`endif
        chk("rr header count", hq.size() >= exp_q.size(), 1);
        for (int i = 0; i < exp_q.size(); i++)
            if (i < hq.size()) chk($sformatf("rr hdr%0d", i), hq[i], exp_q[i]);
        if (wq.size() >= 4) begin
            chk("rr ch0 data", wq[1], 8'h00);
            chk("rr ch1 data", wq[3], 8'h10);
        end

        // ---------------- backpressure in HDR and mid-DATA ----------------
        do_reset();
        for (int i = 0; i < 9; i++) push(0, 8'h50 + 8'(i), 0);
        t0 = cyc + 1;
        for (int k = 0; k < 26; k++) begin
            bit nf;
            nf = !((k >= 1 && k <= 5) || (k >= 9 && k <= 11));
            cycle_start(nf, 1'b0);
            if (!nf) begin
                chk($sformatf("bp wr k%0d", k),    fifo_wr,   0);
                chk($sformatf("bp ready k%0d", k), req_ready, 0);
                chk($sformatf("bp busy k%0d", k),  busy,      1);
            end
        end
        exp_q = '{8'hA0, 8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57,
                  8'hA0, 8'h58};
        check_sink("bp");
        if (wcyc.size() >= 4) begin
            chk("bp hdr cycle",   wcyc[0] - t0, 6);
            chk("bp resume cycle", wcyc[3] - t0, 12);
        end

        // ---------------- gap termination on channel 3 ----------------
        do_reset();
        push(3, 8'h61, 0); push(3, 8'h62, 0);
        for (int k = 0; k <= 4; k++) cycle_start(1'b1, 1'b0);
        chk("gap busy c4", busy, 1);
        push(3, 8'h63, 1);
        cycle_start(1'b1, 1'b0);
        chk("gap busy c5", busy, 0);
        for (int k = 6; k <= 9; k++) cycle_start(1'b1, 1'b0);
        exp_q = '{8'hA3, 8'h61, 8'h62, 8'hA3, 8'h63};
        check_sink("gap");

        // ---------------- reset mid-burst ----------------
        do_reset();
        for (int i = 0; i < 5; i++) push(1, 8'h71 + 8'(i), 0);
        for (int k = 0; k <= 2; k++) cycle_start(1'b1, 1'b0);
        cycle_start(1'b1, 1'b1);
        push(0, 8'h01, 1);
        cycle_start(1'b1, 1'b0);
        chk("mrst fifo_wr",   fifo_wr,   0);
        chk("mrst fifo_data", fifo_data, 0);
        chk("mrst ready",     req_ready, 0);
        chk("mrst grant",     grant,     0);
        chk("mrst busy",      busy,      0);
        cycle_start(1'b1, 1'b0);
        chk("mrst hdr wr",   fifo_wr,   1);
        chk("mrst hdr data", fifo_data, 8'hA0);
        exp_q = '{8'hA1, 8'h71, 8'hA0};
        check_sink("mrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
